// File: rtl/dl_mul_arbiter_pkg.sv
// Shared FPU definitions for the DLfloat16 multiplier arbiter slice.
// Holds the multiplier op-codes, the DLfloat16 width, the exception-flag
// bit positions and a small index-wrap helper used by the round-robin search.
package dl_mul_arbiter_pkg;

  localparam int DLF_W  = 16;
  localparam int FLAG_W = 5;

  localparam logic [3:0] OP_MUL = 4'b0010;
  localparam logic [3:0] OP_NOP = 4'b0000;

  // Exception flag vector layout: {invalid, inexact, overflow, underflow, div_zero}
  localparam int FLG_INVALID   = 4;
  localparam int FLG_INEXACT   = 3;
  localparam int FLG_OVERFLOW  = 2;
  localparam int FLG_UNDERFLOW = 1;
  localparam int FLG_DIV_ZERO  = 0;

  // (base + off) modulo n, assuming base < n and off < n.
  function automatic int wrap_add(input int base, input int off, input int n);
    int sum;
    sum = base + off;
    return (sum >= n) ? (sum - n) : sum;
  endfunction

endpackage

// File: rtl/dl_mul_arbiter_if.sv
// Request / response bundle of the multiplier arbiter.
//   req_valid/req_a/req_b/req_ready : per-requester issue handshake
//   rsp_valid/rsp_id/rsp_data/rsp_flags/rsp_ready : shared response channel
// slave  = arbiter view, master = requesters plus response consumer.
interface dl_mul_arbiter_if
  import dl_mul_arbiter_pkg::*;
#(
  parameter int N_REQ = 4
) ();

  localparam int ID_W = $clog2(N_REQ);

  logic [N_REQ-1:0]       req_valid;
  logic [DLF_W*N_REQ-1:0] req_a;
  logic [DLF_W*N_REQ-1:0] req_b;
  logic [N_REQ-1:0]       req_ready;

  logic                   rsp_valid;
  logic [ID_W-1:0]        rsp_id;
  logic [DLF_W-1:0]       rsp_data;
  logic [FLAG_W-1:0]      rsp_flags;
  logic                   rsp_ready;

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
  );

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_flags
  );

endinterface

// File: rtl/dl_rsp_fifo.sv
// Synchronous response FIFO with occupancy count.
//   clk, rst_n : clock, asynchronous active-low reset
//   push_i/data_i : write request and entry
//   pop_i         : remove head entry (ignored while empty)
//   data_o        : head entry, empty_o : no entries, count_o : occupancy
// Push and pop may happen in the same cycle, also while full, in which case
// the head is retired and the new entry takes a slot in the same edge.
module dl_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [W-1:0]               data_i,
  input  logic                       pop_i,
  output logic [W-1:0]               data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push_s, do_pop_s;

  assign do_pop_s  = pop_i & (cnt_q != CW'(0));
  assign do_push_s = push_i & ((cnt_q != CW'(DEPTH)) | do_pop_s);

  // Next occupancy from the qualified push/pop pair.
  always_comb begin
    cnt_d = cnt_q;
    case ({do_push_s, do_pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Storage, pointers and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      cnt_q <= cnt_d;
      if (do_push_s) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= (wr_q == PW'(DEPTH - 1)) ? PW'(0) : wr_q + PW'(1);
      end
      if (do_pop_s) begin
        rd_q <= (rd_q == PW'(DEPTH - 1)) ? PW'(0) : rd_q + PW'(1);
      end
    end
  end

  assign data_o  = mem_q[rd_q];
  assign empty_o = (cnt_q == CW'(0));
  assign count_o = cnt_q;

endmodule

// File: rtl/dl_mul_arbiter.sv
// Round-robin arbiter sharing one DLfloat16 multiplier among N_REQ requesters.
//   clk, rst_n          : clock, asynchronous active-low reset (shared with multiplier)
//   bus (slave)         : request handshake and shared response channel
//   mul_a_o, mul_b_o    : multiplier operands (zero when idle)
//   mul_ena_o           : OP_MUL when issuing, otherwise OP_NOP
//   mul_result_i        : registered multiplier result, low 16 bits returned
//   mul_flags_i         : exception flags of that result
//   busy_o              : an operation is in flight or a response is queued
// Issue is credit-limited so every result in the tag pipeline is guaranteed a
// FIFO slot; responses therefore leave strictly in issue order.
module dl_mul_arbiter
  import dl_mul_arbiter_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int MUL_LAT    = 1,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  dl_mul_arbiter_if.slave     bus,
  output logic [DLF_W-1:0]    mul_a_o,
  output logic [DLF_W-1:0]    mul_b_o,
  output logic [3:0]          mul_ena_o,
  input  logic [19:0]         mul_result_i,
  input  logic [FLAG_W-1:0]   mul_flags_i,
  output logic                busy_o
);

  localparam int ID_W  = $clog2(N_REQ);
  localparam int ENT_W = ID_W + DLF_W + FLAG_W;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int INF_W = $clog2(MUL_LAT + 1);
  localparam int USE_W = $clog2(FIFO_DEPTH + MUL_LAT + 2);

  logic               run_q;
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [MUL_LAT-1:0] tag_vld_q;
  logic [ID_W-1:0]    tag_id_q [MUL_LAT];

  logic [CNT_W-1:0]   fifo_cnt_s;
  logic               fifo_empty_s;
  logic [ENT_W-1:0]   fifo_head_s;
  logic [ENT_W-1:0]   push_data_s;
  logic               push_s, pop_s;
  logic [INF_W-1:0]   inflight_s;
  logic [USE_W-1:0]   used_s;
  logic               can_issue_s, found_s, issue_s;
  logic [ID_W-1:0]    win_s;
  logic [N_REQ-1:0]   grant_s;
  logic               unused_s;

  assign unused_s = ^mul_result_i[19:16];

  // Holds off grants until the first edge after reset release, so req_ready
  // stays low while rst_n is asserted regardless of req_valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  // Number of operations currently travelling through the multiplier.
  always_comb begin
    inflight_s = '0;
    for (int k = 0; k < MUL_LAT; k++) begin
      inflight_s = inflight_s + INF_W'(tag_vld_q[k]);
    end
  end

  // credit = FIFO_DEPTH - count - inflight + pop > 0, rearranged so no
  // intermediate term can go negative.
  assign pop_s       = ~fifo_empty_s & bus.rsp_ready;
  assign used_s      = USE_W'(fifo_cnt_s) + USE_W'(inflight_s);
  assign can_issue_s = run_q & (used_s < (USE_W'(FIFO_DEPTH) + USE_W'(pop_s)));

  // Round-robin search: scanned from the far end so the requester closest
  // to rr_ptr is the last (winning) write.
  always_comb begin : rr_search
    logic [ID_W-1:0] idx;
    found_s = 1'b0;
    win_s   = '0;
    idx     = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx     = ID_W'(wrap_add(int'(rr_ptr_q), k, N_REQ));
      win_s   = bus.req_valid[idx] ? idx : win_s;
      found_s = found_s | bus.req_valid[idx];
    end
  end

  assign issue_s       = found_s & can_issue_s;
  assign grant_s       = issue_s ? ({{(N_REQ-1){1'b0}}, 1'b1} << win_s) : '0;
  assign bus.req_ready = grant_s;
  assign rr_ptr_d      = issue_s ? ID_W'(wrap_add(int'(win_s), 1, N_REQ)) : rr_ptr_q;

  // Multiplier operand and enable steering.
  always_comb begin
    if (issue_s) begin
      mul_a_o   = bus.req_a[int'(win_s)*DLF_W +: DLF_W];
      mul_b_o   = bus.req_b[int'(win_s)*DLF_W +: DLF_W];
      mul_ena_o = OP_MUL;
    end else begin
      mul_a_o   = '0;
      mul_b_o   = '0;
      mul_ena_o = OP_NOP;
    end
  end

  // Round-robin pointer and the {valid, id} tag shift register that tracks
  // each operation alongside the multiplier pipeline.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q  <= '0;
      tag_vld_q <= '0;
      for (int k = 0; k < MUL_LAT; k++) begin
        tag_id_q[k] <= '0;
      end
    end else begin
      rr_ptr_q     <= rr_ptr_d;
      tag_vld_q[0] <= issue_s;
      tag_id_q[0]  <= win_s;
      for (int k = 1; k < MUL_LAT; k++) begin
        tag_vld_q[k] <= tag_vld_q[k-1];
        tag_id_q[k]  <= tag_id_q[k-1];
      end
    end
  end

  assign push_s      = tag_vld_q[MUL_LAT-1];
  assign push_data_s = {tag_id_q[MUL_LAT-1], mul_result_i[DLF_W-1:0], mul_flags_i};

  dl_rsp_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ENT_W)
  ) u_rsp_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (push_s),
    .data_i  (push_data_s),
    .pop_i   (pop_s),
    .data_o  (fifo_head_s),
    .empty_o (fifo_empty_s),
    .count_o (fifo_cnt_s)
  );

  // Response fields are forced to zero while the FIFO is empty so stale
  // storage never shows on the channel.
  assign bus.rsp_valid = ~fifo_empty_s;
  assign bus.rsp_id    = fifo_empty_s ? '0 : fifo_head_s[ENT_W-1 -: ID_W];
  assign bus.rsp_data  = fifo_empty_s ? '0 : fifo_head_s[FLAG_W +: DLF_W];
  assign bus.rsp_flags = fifo_empty_s ? '0 : fifo_head_s[FLAG_W-1:0];

  assign busy_o = (inflight_s != INF_W'(0)) | ~fifo_empty_s;

endmodule

// File: tb/tb_dl_mul_arbiter.sv
// Directed plus randomised bench for dl_mul_arbiter with a 1-cycle
// multiplier stub (result = {4'b0, a^b}, flags = a[4:0]).
// The reference model keeps an ordered list of issued operations, each with
// the cycle at which its response becomes visible; FIFO occupancy plus
// in-flight work is simply the list length.
module tb_dl_mul_arbiter;
  import dl_mul_arbiter_pkg::*;

  localparam int N_REQ      = 4;
  localparam int MUL_LAT    = 1;
  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] mul_a, mul_b;
  logic [3:0]  mul_ena;
  logic [19:0] mul_result;
  logic [4:0]  mul_flags;
  logic        busy;

  always #5 clk = ~clk;

  dl_mul_arbiter_if #(.N_REQ(N_REQ)) bus ();

  dl_mul_arbiter #(
    .N_REQ      (N_REQ),
    .MUL_LAT    (MUL_LAT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus.slave),
    .mul_a_o      (mul_a),
    .mul_b_o      (mul_b),
    .mul_ena_o    (mul_ena),
    .mul_result_i (mul_result),
    .mul_flags_i  (mul_flags),
    .busy_o       (busy)
  );

  // Multiplier stub sharing the arbiter reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mul_result <= 20'h0;
      mul_flags  <= 5'h0;
    end else begin
      mul_result <= {4'b0000, mul_a ^ mul_b};
      mul_flags  <= mul_a[4:0];
    end
  end

  typedef struct {
    int          id;
    logic [15:0] data;
    logic [4:0]  flags;
    int          rdy;
  } ent_t;

  ent_t        pend[$];
  int          cyc = 0;
  int          rr_m = 0;
  logic [3:0]  last_acc = 4'b0000;
  int          total = 0;
  int          bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [15:0] a, input logic [15:0] b);
    bus.req_a[i*16 +: 16] = a;
    bus.req_b[i*16 +: 16] = b;
    bus.req_valid[i]      = 1'b1;
  endtask

  task automatic model_reset();
    pend.delete();
    rr_m     = 0;
    last_acc = 4'b0000;
  endtask

  // Compare DUT against the model at the negedge, then advance the model
  // across the following posedge.
  task automatic sample();
    int         vis;
    int         win;
    int         j;
    int         credit;
    bit         evld;
    bit         pop;
    bit         gnt;
    logic [3:0] exp_rdy;
    logic [15:0] wa, wb;
    ent_t       e;
    @(negedge clk);
    vis = 0;
    foreach (pend[k]) if (pend[k].rdy <= cyc) vis++;
    evld = (vis > 0);
    chk("rsp_valid", bus.rsp_valid, evld);
    if (evld) begin
      chk("rsp_id", bus.rsp_id, pend[0].id);
      chk("rsp_data", bus.rsp_data, pend[0].data);
      chk("rsp_flags", bus.rsp_flags, pend[0].flags);
    end
    chk("busy", busy, pend.size() > 0);
    pop    = evld && bus.rsp_ready;
    credit = FIFO_DEPTH - pend.size() + (pop ? 1 : 0);
    win    = -1;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      j = (rr_m + k) % N_REQ;
      if (bus.req_valid[j]) win = j;
    end
    gnt     = (win >= 0) && (credit > 0);
    exp_rdy = gnt ? (4'b0001 << win) : 4'b0000;
    wa      = gnt ? bus.req_a[win*16 +: 16] : 16'h0;
    wb      = gnt ? bus.req_b[win*16 +: 16] : 16'h0;
    chk("req_ready", bus.req_ready, exp_rdy);
    chk("mul_ena", mul_ena, gnt ? 4'b0010 : 4'b0000);
    chk("mul_a", mul_a, wa);
    chk("mul_b", mul_b, wb);
    if (pop) void'(pend.pop_front());
    if (gnt) begin
      e.id    = win;
      e.data  = wa ^ wb;
      e.flags = wa[4:0];
      e.rdy   = cyc + MUL_LAT + 1;
      pend.push_back(e);
      rr_m = (win + 1) % N_REQ;
    end
    last_acc = exp_rdy;
    cyc++;
  endtask

  // Cross the posedge; accepted requesters drop valid or reload new operands.
  task automatic advance(input bit refill);
    @(posedge clk);
    #1;
    for (int i = 0; i < N_REQ; i++) begin
      if (last_acc[i]) begin
        if (refill) set_req(i, 16'($urandom), 16'($urandom));
        else bus.req_valid[i] = 1'b0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      sample();
      advance(1'b0);
    end
  endtask

  int acc;
  int seq_ok;

  initial begin
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;

    // Reset state, with all requesters valid to show req_ready is held low.
    bus.req_valid = 4'b1111;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req_ready", bus.req_ready, 4'b0000);
    chk("rst_mul_ena", mul_ena, 4'b0000);
    chk("rst_mul_a", mul_a, 16'h0);
    chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("rst_rsp_data", bus.rsp_data, 16'h0);
    chk("rst_busy", busy, 1'b0);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    bus.rsp_ready = 1'b1;
    idle(2);

    // Single request from requester 2: response two cycles after acceptance.
    set_req(2, 16'h3E00, 16'h0001);
    sample();
    chk("single_grant", bus.req_ready, 4'b0100);
    advance(1'b0);
    sample();
    chk("single_not_yet", bus.rsp_valid, 1'b0);
    advance(1'b0);
    sample();
    chk("single_valid", bus.rsp_valid, 1'b1);
    chk("single_id", bus.rsp_id, 2'd2);
    chk("single_data", bus.rsp_data, 16'h3E01);
    chk("single_flags", bus.rsp_flags, 5'b00000);
    advance(1'b0);
    idle(1);

    // Flags pass through unchanged (rr_ptr ends at 2 after this).
    set_req(1, 16'h0013, 16'h0100);
    idle(2);
    sample();
    chk("flags_val", bus.rsp_flags, 5'b10011);
    chk("flags_data", bus.rsp_data, 16'h0113);
    advance(1'b0);

    // Requesters 1 and 3 with rr_ptr = 2: 3 first, then 1.
    set_req(1, 16'h1111, 16'h2222);
    set_req(3, 16'h3333, 16'h4444);
    sample();
    chk("rr_first", bus.req_ready, 4'b1000);
    advance(1'b0);
    sample();
    chk("rr_second", bus.req_ready, 4'b0010);
    advance(1'b0);
    idle(3);

    // All four requesters continuously valid: one grant per cycle from rr_ptr = 2.
    for (int i = 0; i < N_REQ; i++) set_req(i, 16'($urandom), 16'($urandom));
    seq_ok = 1;
    for (int k = 0; k < 8; k++) begin
      sample();
      if (last_acc !== (4'b0001 << ((2 + k) % N_REQ))) seq_ok = 0;
      advance(1'b1);
    end
    chk("all_rr_seq", seq_ok, 1);
    bus.req_valid = '0;
    idle(4);

    // Backpressure: exactly FIFO_DEPTH accepts, then drain in order and resume.
    bus.rsp_ready = 1'b0;
    set_req(0, 16'h0A0A, 16'h0505);
    acc = 0;
    for (int k = 0; k < 6; k++) begin
      sample();
      acc += last_acc[0];
      advance(1'b1);
    end
    chk("bp_accepts", acc, FIFO_DEPTH);
    chk("bp_ready_low", bus.req_ready, 4'b0000);
    bus.rsp_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      sample();
      acc += last_acc[0];
      advance(1'b1);
    end
    chk("bp_resume", acc > 0, 1'b1);
    bus.req_valid = '0;
    idle(4);

    // Reset with one op in the FIFO and one in flight.
    bus.rsp_ready = 1'b0;
    set_req(0, 16'h1234, 16'h0F0F);
    sample();
    advance(1'b1);
    sample();
    advance(1'b0);
    chk("pre_rst_valid", bus.rsp_valid, 1'b1);
    chk("pre_rst_busy", busy, 1'b1);
    bus.req_valid = 4'b1111;
    rst_n = 1'b0;
    #1;
    chk("arst_rsp_valid", bus.rsp_valid, 1'b0);
    chk("arst_rsp_id", bus.rsp_id, 2'd0);
    chk("arst_rsp_data", bus.rsp_data, 16'h0);
    chk("arst_rsp_flags", bus.rsp_flags, 5'h0);
    chk("arst_busy", busy, 1'b0);
    chk("arst_req_ready", bus.req_ready, 4'b0000);
    chk("arst_mul_ena", mul_ena, 4'b0000);
    bus.req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    model_reset();
    bus.rsp_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 4; k++) begin
      sample();
      acc += bus.rsp_valid;
      advance(1'b0);
    end
    chk("post_rst_no_rsp", acc, 0);
    set_req(3, 16'h5555, 16'h0101);
    set_req(1, 16'h6666, 16'h0202);
    sample();
    chk("post_rst_lowest", bus.req_ready, 4'b0010);
    advance(1'b0);
    idle(4);

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < N_REQ; i++) begin
        if (!bus.req_valid[i] && ($urandom_range(0, 2) == 0))
          set_req(i, 16'($urandom), 16'($urandom));
      end
      bus.rsp_ready = ($urandom_range(0, 3) != 0);
      sample();
      advance(1'b0);
    end
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    idle(5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
